// File: rtl/unary_add_n.sv
// unary_add_n: N-input unary (bitstream) accumulator with unary drain.
//
// Read phase  (read_or_write=0): adds popcount(din) to the counter and flags
//   overflow on C whenever the true sum exceeds 2^CNT_W-1.
// Write phase (read_or_write=1): emits up to OUT_W ones per cycle on dout
//   (thermometer, LSB first), decrements the counter by the amount emitted and
//   pulses done on the chunk that empties it.
//
// Optional feature macro: UNARY_SAT_EN
//   defined   -> the counter saturates at 2^CNT_W-1 on overflow
//   undefined -> the counter wraps modulo 2^CNT_W (default)
//
// Ports:
//   clk           in   1       rising-edge clock
//   rst_n         in   1       asynchronous active-low reset
//   en            in   1       cycle enable; 0 holds all state and outputs
//   read_or_write in   1       0 = accumulate, 1 = drain
//   din           in   NUM_IN  one bit per input stream per cycle
//   dout          out  OUT_W   registered unary chunk
//   C             out  1       registered overflow flag for the last read
//   done          out  1       registered pulse on the final drain chunk
//   count_o       out  CNT_W   current accumulator register

module unary_add_n #(
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 13,
  parameter int unsigned OUT_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              read_or_write,
  input  logic [NUM_IN-1:0] din,
  output logic [OUT_W-1:0]  dout,
  output logic              C,
  output logic              done,
  output logic [CNT_W-1:0]  count_o
);

  // Popcount needs enough bits to hold NUM_IN itself.
  localparam int unsigned PopW = $clog2(NUM_IN + 1);
  // Sum width wide enough that count + popcount never loses a carry.
  localparam int unsigned SumW = CNT_W + PopW;

  localparam logic [CNT_W-1:0] OutWC = CNT_W'(OUT_W);

  logic [CNT_W-1:0] r_count;
  logic [OUT_W-1:0] r_dout;
  logic             r_c;
  logic             r_done;

  logic [PopW-1:0]  w_pop;
  logic [SumW-1:0]  w_sum;
  logic             w_ovf;
  logic [CNT_W-1:0] w_rd_count;
  logic [CNT_W-1:0] w_take;
  logic             w_last;
  logic [OUT_W-1:0] w_therm;

  logic [CNT_W-1:0] w_count_nxt;
  logic [OUT_W-1:0] w_dout_nxt;
  logic             w_c_nxt;
  logic             w_done_nxt;

  // Read datapath ------------------------------------------------------------

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_pop = w_pop + PopW'(din[i]);
    end
  end

  assign w_sum = SumW'(r_count) + SumW'(w_pop);
  // Any bit above the counter width means the true sum exceeds the max count.
  assign w_ovf = |w_sum[SumW-1:CNT_W];

`ifdef UNARY_SAT_EN
  assign w_rd_count = w_ovf ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
`else
  assign w_rd_count = w_sum[CNT_W-1:0];
`endif

  // Write datapath -----------------------------------------------------------

  // Amount drained this cycle: min(count, OUT_W). A zero count drains nothing.
  assign w_take = (r_count <= OutWC) ? r_count : OutWC;
  assign w_last = (r_count != '0) && (r_count <= OutWC);

  // Lane i is lit iff more than i units remain, which gives min(count, OUT_W)
  // ones packed from the LSB.
  always_comb begin
    w_therm = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_therm[i] = (r_count > CNT_W'(i));
    end
  end

  // Next state ---------------------------------------------------------------

  always_comb begin
    w_count_nxt = r_count;
    w_dout_nxt  = '0;
    w_c_nxt     = 1'b0;
    w_done_nxt  = 1'b0;
    if (read_or_write) begin
      w_count_nxt = r_count - w_take;
      w_dout_nxt  = w_therm;
      w_done_nxt  = w_last;
    end else begin
      w_count_nxt = w_rd_count;
      w_c_nxt     = w_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_dout  <= '0;
      r_c     <= 1'b0;
      r_done  <= 1'b0;
    end else if (en) begin
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_c     <= w_c_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign dout    = r_dout;
  assign C       = r_c;
  assign done    = r_done;
  assign count_o = r_count;

endmodule

// File: tb/tb_unary_add_n.sv
// Scoreboard bench for unary_add_n: one default instance (2 in, 13-bit, 1 lane)
// and one small instance (4 in, 4-bit, 3 lanes). Each driven cycle pushes its
// expected registered response; per-instance monitors pop on the next falling
// edge and compare.

module tb_unary_add_n;

`ifdef UNARY_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct packed {
    logic [12:0] cnt;
    logic [2:0]  dout;
    logic        c;
    logic        done;
    logic [15:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        en_a, rw_a;
  logic [1:0]  din_a;
  logic [0:0]  dout_a;
  logic        c_a, done_a;
  logic [12:0] count_a;

  logic        en_b, rw_b;
  logic [3:0]  din_b;
  logic [2:0]  dout_b;
  logic        c_b, done_b;
  logic [3:0]  count_b;

  logic vld_a, vld_b, vq_a, vq_b;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unary_add_n #(.NUM_IN(2), .CNT_W(13), .OUT_W(1)) u_dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en_a),
    .read_or_write(rw_a),
    .din          (din_a),
    .dout         (dout_a),
    .C            (c_a),
    .done         (done_a),
    .count_o      (count_a)
  );

  unary_add_n #(.NUM_IN(4), .CNT_W(4), .OUT_W(3)) u_dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en_b),
    .read_or_write(rw_b),
    .din          (din_b),
    .dout         (dout_b),
    .C            (c_b),
    .done         (done_b),
    .count_o      (count_b)
  );

  // Marks which cycles carry a queued expectation.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vq_a <= 1'b0;
      vq_b <= 1'b0;
    end else begin
      vq_a <= vld_a;
      vq_b <= vld_b;
    end
  end

  always @(negedge clk) begin
    if (vq_a) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL dut_a scoreboard empty at output time");
      end else begin
        ea = q_a.pop_front();
        if ({count_a, dout_a, c_a, done_a} !== {ea.cnt, ea.dout[0], ea.c, ea.done}) begin
          n_fail++;
          $display("FAIL dut_a tag=%0d got cnt=%0d dout=%b C=%b done=%b exp cnt=%0d dout=%b C=%b done=%b",
                   ea.tag, count_a, dout_a, c_a, done_a, ea.cnt, ea.dout[0], ea.c, ea.done);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vq_b) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL dut_b scoreboard empty at output time");
      end else begin
        eb = q_b.pop_front();
        if ({count_b, dout_b, c_b, done_b} !== {eb.cnt[3:0], eb.dout, eb.c, eb.done}) begin
          n_fail++;
          $display("FAIL dut_b tag=%0d got cnt=%0d dout=%b C=%b done=%b exp cnt=%0d dout=%b C=%b done=%b",
                   eb.tag, count_b, dout_b, c_b, done_b, eb.cnt[3:0], eb.dout, eb.c, eb.done);
        end
      end
    end
  end

  task automatic step_a(input logic e, input logic rw, input logic [1:0] d,
                        input logic [12:0] cnt, input logic dq, input logic c,
                        input logic dn, input int tag);
    exp_t x;
    @(negedge clk);
    en_a = e; rw_a = rw; din_a = d; vld_a = 1'b1;
    x.cnt = cnt; x.dout = {2'b00, dq}; x.c = c; x.done = dn; x.tag = 16'(tag);
    q_a.push_back(x);
  endtask

  task automatic step_b(input logic e, input logic rw, input logic [3:0] d,
                        input logic [3:0] cnt, input logic [2:0] dq, input logic c,
                        input logic dn, input int tag);
    exp_t x;
    @(negedge clk);
    en_b = e; rw_b = rw; din_b = d; vld_b = 1'b1;
    x.cnt = {9'd0, cnt}; x.dout = dq; x.c = c; x.done = dn; x.tag = 16'(tag);
    q_b.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic check_zero();
    chk("rst_count_a", 32'(count_a), 32'd0);
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_c_a", 32'(c_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_count_b", 32'(count_b), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_c_b", 32'(c_b), 32'd0);
    chk("rst_done_b", 32'(done_b), 32'd0);
  endtask

  // Reset lands 1 time unit after a falling edge, once the monitors have
  // consumed the pending response, and is checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    #1;
    check_zero();
    chk("rst_queue_a", 32'(q_a.size()), 32'd0);
    chk("rst_queue_b", 32'(q_b.size()), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; rw_a = 1'b0; din_a = '0; vld_a = 1'b0;
    en_b = 1'b0; rw_b = 1'b0; din_b = '0; vld_b = 1'b0;
    #2;
    check_zero();
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Multi-lane accumulate and drain.
    step_b(1, 0, 4'b1111, 4'd4, 3'b000, 0, 0, 100);
    step_b(1, 0, 4'b0111, 4'd7, 3'b000, 0, 0, 101);
    step_b(1, 1, 4'b0000, 4'd4, 3'b111, 0, 0, 102);
    step_b(1, 1, 4'b0000, 4'd1, 3'b111, 0, 0, 103);
    step_b(1, 1, 4'b0000, 4'd0, 3'b001, 0, 1, 104);
    step_b(1, 1, 4'b0000, 4'd0, 3'b000, 0, 0, 105);
    // Count exactly OUT_W drains in one chunk.
    step_b(1, 0, 4'b0111, 4'd3, 3'b000, 0, 0, 106);
    step_b(1, 1, 4'b0000, 4'd0, 3'b111, 0, 1, 107);
    // Interleave with overflow.
    step_b(1, 0, 4'b1111, 4'd4, 3'b000, 0, 0, 108);
    step_b(1, 0, 4'b1111, 4'd8, 3'b000, 0, 0, 109);
    step_b(1, 0, 4'b1111, 4'd12, 3'b000, 0, 0, 110);
    step_b(1, 0, 4'b0011, 4'd14, 3'b000, 0, 0, 111);
    step_b(1, 0, 4'b0011, Sat ? 4'd15 : 4'd0, 3'b000, 1, 0, 112);
    step_b(1, 1, 4'b0000, Sat ? 4'd12 : 4'd0, Sat ? 3'b111 : 3'b000, 0, 0, 113);
    step_b(1, 1, 4'b0000, Sat ? 4'd9 : 4'd0, Sat ? 3'b111 : 3'b000, 0, 0, 114);
    step_b(1, 0, 4'b0001, Sat ? 4'd10 : 4'd1, 3'b000, 0, 0, 115);
    step_b(1, 0, 4'b1000, Sat ? 4'd11 : 4'd2, 3'b000, 0, 0, 116);
    step_b(1, 0, 4'b0000, Sat ? 4'd11 : 4'd2, 3'b000, 0, 0, 117);
    do_reset();

    // Default accumulate then drain 20 ones.
    for (int k = 1; k <= 10; k++) step_a(1, 0, 2'b11, 13'(2 * k), 0, 0, 0, 200);
    for (int j = 1; j <= 25; j++)
      step_a(1, 1, 2'b00, (j <= 20) ? 13'(20 - j) : 13'd0, (j <= 20), 0, (j == 20), 201);

    // Stalls inside a drain hold dout/done.
    for (int k = 1; k <= 3; k++) step_a(1, 0, 2'b01, 13'(k), 0, 0, 0, 202);
    step_a(1, 1, 2'b00, 13'd2, 1, 0, 0, 203);
    step_a(1, 1, 2'b00, 13'd1, 1, 0, 0, 203);
    for (int k = 0; k < 3; k++) step_a(0, 0, 2'b11, 13'd1, 1, 0, 0, 204);
    step_a(1, 1, 2'b00, 13'd0, 1, 0, 1, 205);
    for (int k = 0; k < 2; k++) step_a(0, 1, 2'b00, 13'd0, 1, 0, 1, 206);
    step_a(1, 0, 2'b00, 13'd0, 0, 0, 0, 207);

    // Reset mid-drain with count 5.
    step_a(1, 0, 2'b11, 13'd2, 0, 0, 0, 208);
    step_a(1, 0, 2'b11, 13'd4, 0, 0, 0, 208);
    step_a(1, 0, 2'b11, 13'd6, 0, 0, 0, 208);
    step_a(1, 0, 2'b10, 13'd7, 0, 0, 0, 208);
    step_a(1, 1, 2'b00, 13'd6, 1, 0, 0, 209);
    step_a(1, 1, 2'b00, 13'd5, 1, 0, 0, 209);
    do_reset();

    // Wrap / saturate from 8190.
    for (int k = 1; k <= 4095; k++) step_a(1, 0, 2'b11, 13'(2 * k), 0, 0, 0, 210);
    step_a(1, 0, 2'b11, Sat ? 13'd8191 : 13'd0, 0, 1, 0, 211);
    do_reset();

    // Exact-max boundary, then one past it.
    for (int k = 1; k <= 4094; k++) step_a(1, 0, 2'b11, 13'(2 * k), 0, 0, 0, 212);
    step_a(1, 0, 2'b01, 13'd8189, 0, 0, 0, 213);
    step_a(1, 0, 2'b11, 13'd8191, 0, 0, 0, 214);
    step_a(1, 0, 2'b01, Sat ? 13'd8191 : 13'd0, 0, 1, 0, 215);
    step_a(1, 0, 2'b00, Sat ? 13'd8191 : 13'd0, 0, 0, 0, 216);
    step_a(1, 1, 2'b00, Sat ? 13'd8190 : 13'd0, Sat, 0, 0, 217);

    @(negedge clk);
    vld_a = 1'b0; vld_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    @(negedge clk);
    chk("end_queue_a", 32'(q_a.size()), 32'd0);
    chk("end_queue_b", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
